mul_div_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO result registers; next

---
 rtl/mul_div_unit_pkg.sv | 36 +++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_cond_negate.sv | 10 +
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states,
// latched per-operation control flags and small op-decode helpers.
package mul_div_unit_pkg;

    localparam int unsigned MD_N = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Per-operation flags captured at acceptance
    typedef struct packed {
        md_op_e op;
        logic   res_neg;
        logic   dvd_neg;
        logic   div_zero;
    } md_ctl_t;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bus between EX control and the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned N = MD_N
);
    logic         start;
    md_op_e       op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         dz;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, in_a, in_b, hi_wen, lo_wen, wd,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, in_a, in_b, hi_wen, lo_wen, wd,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_cond_negate.sv
// Conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module mul_div_unit_cond_negate #(
    parameter int unsigned W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) / divide (restoring) unit
// with architectural HI/LO registers.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned N = MD_N
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned W2 = 2 * N;

    md_state_e     r_state, w_state_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          w_accept, w_load;
    md_ctl_t       r_ctl;
    logic [CW-1:0] r_cnt;
    logic [W2-1:0] r_acc;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_hi, r_lo;
    logic          r_dz;

    // Operand magnitudes for signed ops
    logic         w_sgn, w_is_div;
    logic [N-1:0] w_mag_a, w_mag_b;
    assign w_sgn    = op_is_signed(bus.op);
    assign w_is_div = op_is_div(bus.op);

    mul_div_unit_cond_negate #(.W(N)) u_neg_a (
        .i_neg (w_sgn & bus.in_a[N-1]),
        .i_val (bus.in_a),
        .o_val (w_mag_a)
    );
    mul_div_unit_cond_negate #(.W(N)) u_neg_b (
        .i_neg (w_sgn & bus.in_b[N-1]),
        .i_val (bus.in_b),
        .o_val (w_mag_b)
    );

    // Shift-add step: acc = {partial, multiplier}; r_b holds the multiplicand
    logic [N:0]    w_mul_sum;
    logic [W2-1:0] w_mul_step;
    assign w_mul_sum  = {1'b0, r_acc[W2-1:N]} + (r_acc[0] ? {1'b0, r_b} : {(N+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[N-1:1]};

    // Restoring step: acc = {remainder, dividend/quotient}; r_b holds the divisor
    logic [N:0]    w_shift;
    logic [N+1:0]  w_trial;
    logic          w_qbit;
    logic [N-1:0]  w_rem_nxt;
    logic [W2-1:0] w_div_step;
    assign w_shift    = {r_acc[W2-1:N], r_acc[N-1]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, r_b};
    assign w_qbit     = ~w_trial[N+1];
    assign w_rem_nxt  = w_qbit ? w_trial[N-1:0] : w_shift[N-1:0];
    assign w_div_step = {w_rem_nxt, r_acc[N-2:0], w_qbit};

    // Result sign fixup: full product or quotient, and remainder
    logic          w_run_div;
    logic [W2-1:0] w_fix_in, w_fix_out;
    logic [N-1:0]  w_rem_fix;
    assign w_run_div = op_is_div(r_ctl.op);
    assign w_fix_in  = w_run_div ? {{N{1'b0}}, r_acc[N-1:0]} : r_acc;

    mul_div_unit_cond_negate #(.W(W2)) u_fix_res (
        .i_neg (r_ctl.res_neg),
        .i_val (w_fix_in),
        .o_val (w_fix_out)
    );
    mul_div_unit_cond_negate #(.W(N)) u_fix_rem (
        .i_neg (r_ctl.dvd_neg),
        .i_val (r_acc[W2-1:N]),
        .o_val (w_rem_fix)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // FSM next-state and control
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = MD_RUN;
                end
            end
            MD_RUN: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt = MD_FIX;
                end
            end
            MD_FIX: begin
                w_load      = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = MD_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctl.op       <= bus.op;
                r_ctl.res_neg  <= w_sgn & (bus.in_a[N-1] ^ bus.in_b[N-1]);
                r_ctl.dvd_neg  <= w_sgn & w_is_div & bus.in_a[N-1];
                r_ctl.div_zero <= w_is_div & (bus.in_b == '0);
                r_acc          <= {{N{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                r_b            <= w_is_div ? w_mag_b : w_mag_a;
                r_cnt          <= '0;
                r_dz           <= 1'b0;
            end else if (r_state == MD_IDLE) begin
                if (bus.hi_wen) r_hi <= bus.wd;
                if (bus.lo_wen) r_lo <= bus.wd;
            end
            if (r_state == MD_RUN) begin
                r_acc <= w_run_div ? w_div_step : w_mul_step;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_load) begin
                r_dz <= r_ctl.div_zero;
                if (w_run_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= r_ctl.div_zero ? {N{1'b1}} : w_fix_out[N-1:0];
                end else begin
                    r_hi <= w_fix_out[W2-1:N];
                    r_lo <= w_fix_out[N-1:0];
                end
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus multi-cycle corner sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    mul_div_unit_if #(.N(32)) bus ();

    mul_div_unit #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Issue one op at the next negedge and wait (bounded) for done
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic lo_w, output int lat, output int bcnt,
                          output logic done_iss, output logic [31:0] lo_e0);
        @(negedge clk);
        done_iss    = bus.done;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.in_a    = a;
        bus.in_b    = b;
        bus.lo_wen  = lo_w;
        bus.wd      = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.lo_wen  = 1'b0;
        bus.in_a    = ~a;
        bus.in_b    = ~b;
        lo_e0       = bus.lo;
        bcnt        = int'(bus.busy);
        lat         = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int          lat, bcnt, dcnt;
        logic        diss;
        logic [31:0] lo0;

        n_cmp  = 0;
        n_fail = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = MD_MULT;
        bus.in_a   = '0;
        bus.in_b   = '0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wd     = '0;

        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{MD_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[12] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.dz),   32'd0);
        check("rst_hi",   bus.hi,        32'd0);
        check("rst_lo",   bus.lo,        32'd0);

        // Table-driven vectors (issued back-to-back)
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt, diss, lo0);
            check($sformatf("v%0d_latency", i), 32'(lat),     32'd33);
            check($sformatf("v%0d_busy",    i), 32'(bcnt),    32'd33);
            check($sformatf("v%0d_hi",      i), bus.hi,       vecs[i].hi);
            check($sformatf("v%0d_lo",      i), bus.lo,       vecs[i].lo);
            check($sformatf("v%0d_dz",      i), 32'(bus.dz),  32'(vecs[i].dz));
        end

        // Second start and hi_wen during RUN are ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.in_a = 32'd2; bus.in_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = MD_DIVU; bus.in_a = 32'd100; bus.in_b = 32'd7;
        bus.hi_wen = 1'b1; bus.wd = 32'hDEAD0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.hi_wen = 1'b0;
        check("run_hi_wen_dropped", bus.hi, 32'h00000001);
        lat = 5;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_latency", 32'(lat), 32'd33);
        check("ign_hi", bus.hi, 32'd0);
        check("ign_lo", bus.lo, 32'd6);
        @(posedge clk);
        #1;
        check("ign_no_queue", 32'(bus.busy), 32'd0);

        // Async reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MULTU; bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi",   bus.hi,        32'd0);
        check("midrst_lo",   bus.lo,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        run_op(MD_MULTU, 32'd2, 32'd3, 1'b0, lat, bcnt, diss, lo0);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_lo",      bus.lo,   32'd6);

        // IDLE mthi, then mtlo colliding with start
        @(negedge clk);
        bus.hi_wen = 1'b1; bus.wd = 32'h00001234;
        @(posedge clk);
        #1;
        bus.hi_wen = 1'b0;
        check("idle_mthi", bus.hi, 32'h00001234);
        run_op(MD_MULTU, 32'd7, 32'd6, 1'b1, lat, bcnt, diss, lo0);
        check("mtlo_start_lo_e0", lo0,    32'd6);
        check("mtlo_start_lo",    bus.lo, 32'd42);
        check("mtlo_start_hi",    bus.hi, 32'd0);

        // Back-to-back issue in the done cycle
        run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, lat, bcnt, diss, lo0);
        check("b2b_first_lo", bus.lo, 32'd15);
        run_op(MD_MULTU, 32'd4, 32'd5, 1'b0, lat, bcnt, diss, lo0);
        check("b2b_issue_in_done", 32'(diss), 32'd1);
        check("b2b_latency",       32'(lat),  32'd33);
        check("b2b_lo",            bus.lo,    32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
